puf_response_ctrl: RTL and testbench
====================================

Name: puf_response_ctrl

Overview:
- Downstream measurement/response stage of the ring-oscillator PUF.
- Drives challenge selects to the two oscillator muxes and gates the oscillator enable.
- Counts rising edges of the two selected oscillator outputs over a fixed clk-domain window and compares them, giving one response bit per challenge pair.
- Collects N_BITS bits into a response word and presents it on a valid/ready handshake.

Parameters:
- CNT_W, 16, width of each edge counter (saturating).
- WINDOW_CYCLES, 1024, clk cycles per counting window.
- SETTLE_CYCLES, 4, clk cycles of oscillator enable before counting starts.
- N_BITS, 8, response bits per run (1..16).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-high.
- start  in  1  run request; sampled only in IDLE.
- chal_seed  in  4  base challenge index.
- ro_a  in  1  selected oscillator A output (asynchronous to clk).
- ro_b  in  1  selected oscillator B output (asynchronous to clk).
- osc_en  out  1  oscillator enable to both oscillator banks.
- chal_a  out  4  mux select, bank A.
- chal_b  out  4  mux select, bank B.
- busy  out  1  high in any state other than IDLE.
- resp  out  N_BITS  response word.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- tie_seen  out  1  at least one bit in resp came from equal counts.

Behaviour:
- Reset (async, while rst_n=1): state=IDLE, bit index k=0, counters=0.
  - osc_en=0, chal_a=0, chal_b=0, busy=0, resp=0, resp_valid=0, tie_seen=0.
  - Synchronizer flops cleared.
  - Reset asserted mid-run aborts immediately; no partial response is ever presented.
- FSM states: IDLE, SETTLE, COUNT, COMPARE, DONE.
- IDLE:
  - start=1 at a clk edge -> SETTLE with k=0.
  - resp and tie_seen clear at the same time.
  - start in any other state is ignored.
- Challenge schedule for bit k:
  - chal_a = (chal_seed + 2k) mod 16, chal_b = (chal_seed + 2k + 1) mod 16, 4-bit wrap.
  - Both selects are registered and stable from SETTLE entry through COMPARE.
- SETTLE:
  - osc_en=1; both counters held at 0.
  - Lasts exactly SETTLE_CYCLES cycles, then -> COUNT.
- COUNT:
  - osc_en=1; lasts exactly WINDOW_CYCLES cycles.
  - Each ro input passes through a 2-flop synchronizer plus a rising-edge detector (third flop).
  - The counter increments by 1 per detected edge.
  - The counter saturates at 2^CNT_W-1 and never wraps.
- COMPARE (1 cycle):
  - osc_en=0.
  - resp[k] = (cnt_a > cnt_b).
  - If cnt_a == cnt_b: resp[k]=0 and tie_seen set (sticky until the next run start).
  - If k==N_BITS-1 -> DONE; otherwise k increments and state -> SETTLE.
- Per-bit latency: SETTLE_CYCLES + WINDOW_CYCLES + 1 cycles.
  - resp_valid rises N_BITS*(SETTLE_CYCLES+WINDOW_CYCLES+1) cycles after the start-sampling edge.
- DONE:
  - resp_valid=1; resp and tie_seen held stable.
  - Handshake completes on a clk edge with resp_valid & resp_ready -> IDLE, resp_valid=0.
  - resp keeps its value until the next start.
  - resp_ready asserted before DONE has no effect.
- Edges are counted only in COUNT; synchronizer history is not cleared between bits.
  - An edge in flight at the SETTLE/COUNT boundary is counted at most once.

Decomposition:
- Package puf_pkg holds:
  - the state enum (IDLE, SETTLE, COUNT, COMPARE, DONE);
  - default constants for CNT_W, WINDOW_CYCLES, SETTLE_CYCLES, N_BITS;
  - the 4-bit challenge width constant.
- Sub-module puf_edge_counter: synchronizer, edge detector, saturating CNT_W counter, with clear and count-enable inputs.
  - Instantiated twice, once for ro_a and once for ro_b.
- The FSM, challenge generation and response register live in the top module.

Test Plan:
- Bench parameters: WINDOW_CYCLES=64, SETTLE_CYCLES=4, N_BITS=4, chal_seed=0, clk period 10 ns.
- Basic run: ro_a period 40 ns, ro_b period 80 ns.
  - Expect chal pairs (0,1),(2,3),(4,5),(6,7).
  - Counts about 16 vs 8 each bit, resp=4'b1111, tie_seen=0.
  - resp_valid rises exactly 276 cycles after start.
- Swap the frequencies, ro_a 80 ns and ro_b 40 ns: resp=4'b0000, tie_seen=0.
- Challenge wrap: chal_seed=14, both ro at 40 ns.
  - Pairs (14,15),(0,1),(2,3),(4,5).
  - Equal counts give resp=0, tie_seen=1.
- Saturation: CNT_W=4, ro_a at 20 ns, ro_b at 40 ns.
  - Both counters saturate at 15, tie, resp bit=0.
- Handshake and reset:
  - Hold resp_ready=0 for 10 cycles after valid: resp and resp_valid stay stable; ready=1 returns to IDLE.
  - start pulsed while busy is ignored.
  - rst_n=1 asserted during COUNT of bit 2: osc_en=0 and busy=0 immediately, resp=0, resp_valid never asserts.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and defaults for the ring-oscillator PUF response controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package puf_pkg;

    // Width of one oscillator mux select; the schedule wraps modulo 2**CHAL_W.
    localparam int CHAL_W = 4;

    // Default build parameters for the response controller.
    localparam int DEF_CNT_W         = 16;
    localparam int DEF_WINDOW_CYCLES = 1024;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_N_BITS        = 8;

    typedef logic [CHAL_W-1:0] chal_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_COUNT   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Select for bit k: seed + 2k (+1 for bank B), wrapping in 4 bits.
    // Only k[2:0] matters because 2k is taken modulo 16.
    function automatic chal_t chal_for_bit(input chal_t seed, input chal_t k, input logic odd);
        return seed + {k[2:0], odd};
    endfunction

endpackage

// File: rtl/puf_response_ctrl_if.sv
// Control, oscillator and response signals of the PUF response controller.
// Latency: n/a (wiring only).
// Backpressure: resp_valid/resp_ready handshake; start is a level sampled only when idle.
interface puf_response_ctrl_if
    import puf_pkg::*;
#(
    parameter int N_BITS = DEF_N_BITS
);

    // Run request side
    logic              start;
    chal_t             chal_seed;
    logic              busy;

    // Oscillator bank side
    logic              ro_a;
    logic              ro_b;
    logic              osc_en;
    chal_t             chal_a;
    chal_t             chal_b;

    // Response side
    logic [N_BITS-1:0] resp;
    logic              resp_valid;
    logic              resp_ready;
    logic              tie_seen;

    // Requester / consumer / oscillator model
    modport master (
        output start, chal_seed, ro_a, ro_b, resp_ready,
        input  busy, osc_en, chal_a, chal_b, resp, resp_valid, tie_seen
    );

    // The response controller itself
    modport slave (
        input  start, chal_seed, ro_a, ro_b, resp_ready,
        output busy, osc_en, chal_a, chal_b, resp, resp_valid, tie_seen
    );

endinterface

// File: rtl/puf_edge_counter.sv
// Counts rising edges of an asynchronous oscillator output in the clk domain, saturating.
// Latency: an ro edge reaches the count 3 clk edges later (2 sync flops + history flop).
// Backpressure: none; edges outside cnt_en are dropped, clr has priority over counting.
module puf_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro,
    input  logic             clr,
    input  logic             cnt_en,
    output logic [CNT_W-1:0] cnt
);

    // sync_q[0], sync_q[1]: metastability chain; sync_q[2]: previous synchronized level
    logic [2:0]       sync_q;
    logic             edge_det;
    logic [CNT_W-1:0] cnt_q;

    // Synchronizer and edge history run continuously so no edge is double-counted across windows
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], ro};
        end
    end

    // One-cycle pulse per synchronized rising edge, so a boundary edge counts at most once
    assign edge_det = sync_q[1] & ~sync_q[2];

    // Saturating edge counter: clears on request, otherwise steps once per edge while enabled
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (cnt_en && edge_det && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/puf_response_ctrl.sv
// Steps challenge pairs through the RO banks, races their edge counts and packs one bit per pair.
// Latency: resp_valid rises N_BITS*(SETTLE_CYCLES+WINDOW_CYCLES+1) cycles after the start edge.
// Backpressure: resp and resp_valid held in DONE until resp_ready; start ignored while busy.
module puf_response_ctrl
    import puf_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int N_BITS        = DEF_N_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    puf_response_ctrl_if.slave bus
);

    // One phase timer serves both SETTLE and COUNT; sized for the longer of the two.
    localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    state_t            state_q;
    state_t            state_d;

    logic [TMR_W-1:0]  tmr_q;
    logic              settle_last;
    logic              window_last;

    chal_t             k_q;
    chal_t             seed_q;
    chal_t             chal_a_q;
    chal_t             chal_b_q;
    logic              last_bit;

    logic [N_BITS-1:0] resp_q;
    logic              tie_q;

    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;
    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_gt;
    logic              cnt_eq;

    logic              osc_en;
    logic              busy;
    logic              resp_valid;

    assign settle_last = (tmr_q == TMR_W'(SETTLE_CYCLES - 1));
    assign window_last = (tmr_q == TMR_W'(WINDOW_CYCLES - 1));
    assign last_bit    = (k_q == CHAL_W'(N_BITS - 1));
    assign cnt_gt      = (cnt_a > cnt_b);
    assign cnt_eq      = (cnt_a == cnt_b);

    // Counters sit at zero while idle and settling, and count only inside the window
    assign cnt_clr = (state_q == ST_IDLE) || (state_q == ST_SETTLE);
    assign cnt_en  = (state_q == ST_COUNT);

    puf_edge_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .ro     (bus.ro_a),
        .clr    (cnt_clr),
        .cnt_en (cnt_en),
        .cnt    (cnt_a)
    );

    puf_edge_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .ro     (bus.ro_b),
        .clr    (cnt_clr),
        .cnt_en (cnt_en),
        .cnt    (cnt_b)
    );

    // State register; reset aborts any run in progress
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: fixed-length SETTLE and COUNT phases, one COMPARE per bit, DONE waits for ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.start)      state_d = ST_SETTLE;
            ST_SETTLE:  if (settle_last)    state_d = ST_COUNT;
            ST_COUNT:   if (window_last)    state_d = ST_COMPARE;
            ST_COMPARE:                     state_d = last_bit ? ST_DONE : ST_SETTLE;
            ST_DONE:    if (bus.resp_ready) state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state: oscillators run only while settling or counting
    always_comb begin
        osc_en     = 1'b0;
        busy       = 1'b1;
        resp_valid = 1'b0;
        case (state_q)
            ST_IDLE:             busy       = 1'b0;
            ST_SETTLE, ST_COUNT: osc_en     = 1'b1;
            ST_COMPARE:          osc_en     = 1'b0;
            ST_DONE:             resp_valid = 1'b1;
            default:             busy       = 1'b0;
        endcase
    end

    // Phase timer restarts on every state change so each phase has an exact length
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tmr_q <= '0;
        end else if (state_q != state_d) begin
            tmr_q <= '0;
        end else if ((state_q == ST_SETTLE) || (state_q == ST_COUNT)) begin
            tmr_q <= tmr_q + TMR_W'(1);
        end
    end

    // Bit index and challenge selects: loaded at start, advanced after each compare,
    // so the selects are stable for the whole SETTLE..COMPARE span of a bit
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            k_q      <= '0;
            seed_q   <= '0;
            chal_a_q <= '0;
            chal_b_q <= '0;
        end else if ((state_q == ST_IDLE) && bus.start) begin
            k_q      <= '0;
            seed_q   <= bus.chal_seed;
            chal_a_q <= chal_for_bit(bus.chal_seed, '0, 1'b0);
            chal_b_q <= chal_for_bit(bus.chal_seed, '0, 1'b1);
        end else if ((state_q == ST_COMPARE) && !last_bit) begin
            k_q      <= k_q + CHAL_W'(1);
            chal_a_q <= chal_for_bit(seed_q, k_q + CHAL_W'(1), 1'b0);
            chal_b_q <= chal_for_bit(seed_q, k_q + CHAL_W'(1), 1'b1);
        end
    end

    // Response word and sticky tie flag: cleared at run start, one bit written per compare,
    // otherwise held (including after the handshake) until the next start
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            resp_q <= '0;
            tie_q  <= 1'b0;
        end else if ((state_q == ST_IDLE) && bus.start) begin
            resp_q <= '0;
            tie_q  <= 1'b0;
        end else if (state_q == ST_COMPARE) begin
            for (int i = 0; i < N_BITS; i++) begin
                if (k_q == CHAL_W'(i)) begin
                    resp_q[i] <= cnt_gt;
                end
            end
            if (cnt_eq) begin
                tie_q <= 1'b1;
            end
        end
    end

    assign bus.osc_en     = osc_en;
    assign bus.busy       = busy;
    assign bus.resp_valid = resp_valid;
    assign bus.chal_a     = chal_a_q;
    assign bus.chal_b     = chal_b_q;
    assign bus.resp       = resp_q;
    assign bus.tie_seen   = tie_q;

endmodule

// File: tb/tb_puf_response_ctrl.sv
// Scoreboard bench for puf_response_ctrl: a 16-bit-counter instance and a 4-bit saturating one.
// Latency: expects resp_valid 276 cycles after the start edge (4 bits x 69 cycles).
// Backpressure: exercises resp_ready held low in DONE and asserted early.
module tb_puf_response_ctrl;
    import puf_pkg::*;

    localparam int NB  = 4;
    localparam int WIN = 64;
    localparam int SET = 4;
    localparam int LAT = 276;

    typedef struct {
        logic [NB-1:0] resp;
        logic          tie;
    } exp_t;

    typedef struct {
        chal_t a;
        chal_t b;
    } pair_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ro_a  = 1'b0;
    logic ro_b  = 1'b0;
    int   ro_a_half = 20;
    int   ro_b_half = 40;

    int   cyc       = 0;
    int   start_cyc = 0;
    int   vec_cnt   = 0;
    int   err_cnt   = 0;

    exp_t  resp_q[$];
    pair_t chal_q[$];
    exp_t  sat_q[$];

    puf_response_ctrl_if #(.N_BITS(NB)) bus0 ();
    puf_response_ctrl_if #(.N_BITS(NB)) bus1 ();

    assign bus0.ro_a = ro_a;
    assign bus0.ro_b = ro_b;
    assign bus1.ro_a = ro_a;
    assign bus1.ro_b = ro_b;

    puf_response_ctrl #(
        .CNT_W(16), .WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SET), .N_BITS(NB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    puf_response_ctrl #(
        .CNT_W(4), .WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SET), .N_BITS(NB)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Oscillators toggle 2 units after a multiple of 10, well clear of clk edges
    initial begin
        #2;
        forever begin
            #(ro_a_half);
            ro_a = ~ro_a;
        end
    end

    initial begin
        #2;
        forever begin
            #(ro_b_half);
            ro_b = ~ro_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor for the main instance: challenge pair at each SETTLE entry, response at valid rise
    logic osc_prev   = 1'b0;
    logic valid_prev = 1'b0;
    always @(negedge clk) begin : mon
        pair_t p;
        exp_t  e;
        if (bus0.osc_en && !osc_prev) begin
            check("chal_pending", 32'(chal_q.size() != 0), 32'd1);
            if (chal_q.size() != 0) begin
                p = chal_q.pop_front();
                check("chal_a", 32'(bus0.chal_a), 32'(p.a));
                check("chal_b", 32'(bus0.chal_b), 32'(p.b));
            end
        end
        if (bus0.resp_valid && !valid_prev) begin
            check("latency", 32'(cyc - start_cyc), 32'(LAT));
            check("resp_pending", 32'(resp_q.size() != 0), 32'd1);
            if (resp_q.size() != 0) begin
                e = resp_q.pop_front();
                check("resp", 32'(bus0.resp), 32'(e.resp));
                check("tie_seen", 32'(bus0.tie_seen), 32'(e.tie));
            end
        end
        osc_prev   <= bus0.osc_en;
        valid_prev <= bus0.resp_valid;
    end

    task automatic run0(input chal_t seed, input logic [NB-1:0] r, input logic t);
        exp_t  e;
        pair_t p;
        e.resp = r;
        e.tie  = t;
        resp_q.push_back(e);
        for (int k = 0; k < NB; k++) begin
            p.a = seed + chal_t'(2 * k);
            p.b = seed + chal_t'(2 * k + 1);
            chal_q.push_back(p);
        end
        @(negedge clk);
        bus0.chal_seed = seed;
        bus0.start     = 1'b1;
        @(negedge clk);
        bus0.start     = 1'b0;
        start_cyc      = cyc;
    endtask

    task automatic wait_valid0();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (bus0.resp_valid) ok = 1'b1;
        end
        check("valid_seen", 32'(ok), 32'd1);
    endtask

    task automatic run_sat(input logic [NB-1:0] r, input logic t);
        exp_t e;
        bit   ok;
        e.resp = r;
        e.tie  = t;
        sat_q.push_back(e);
        @(negedge clk);
        bus1.chal_seed = '0;
        bus1.start     = 1'b1;
        @(negedge clk);
        bus1.start     = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (bus1.resp_valid) ok = 1'b1;
        end
        check("sat_valid_seen", 32'(ok), 32'd1);
        if (ok && sat_q.size() != 0) begin
            e = sat_q.pop_front();
            check("sat_resp", 32'(bus1.resp), 32'(e.resp));
            check("sat_tie", 32'(bus1.tie_seen), 32'(e.tie));
        end
    endtask

    task automatic set_periods(input int ha, input int hb);
        ro_a_half = ha;
        ro_b_half = hb;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int valid_cnt;
        int n;
        bus0.start = 1'b0; bus0.chal_seed = '0; bus0.resp_ready = 1'b1;
        bus1.start = 1'b0; bus1.chal_seed = '0; bus1.resp_ready = 1'b1;

        // Reset state
        #1 rst_n = 1'b1;
        #1;
        check("rst_osc_en", 32'(bus0.osc_en), 32'd0);
        check("rst_busy", 32'(bus0.busy), 32'd0);
        check("rst_chal_a", 32'(bus0.chal_a), 32'd0);
        check("rst_chal_b", 32'(bus0.chal_b), 32'd0);
        check("rst_resp", 32'(bus0.resp), 32'd0);
        check("rst_valid", 32'(bus0.resp_valid), 32'd0);
        check("rst_tie", 32'(bus0.tie_seen), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;

        // Basic: A at 40, B at 80 -> 16 vs 8 edges each bit; ready high before DONE
        set_periods(20, 40);
        run0(4'd0, 4'b1111, 1'b0);
        wait_valid0();
        @(negedge clk);
        check("basic_idle_busy", 32'(bus0.busy), 32'd0);
        check("basic_idle_valid", 32'(bus0.resp_valid), 32'd0);
        check("basic_resp_held", 32'(bus0.resp), 32'hF);

        // Swapped frequencies, plus a start pulse in the middle of the run
        set_periods(40, 20);
        run0(4'd0, 4'b0000, 1'b0);
        repeat (100) @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        check("busy_during_run", 32'(bus0.busy), 32'd1);
        wait_valid0();

        // Challenge wrap with equal frequencies; consumer holds ready low for 10 cycles
        set_periods(20, 20);
        bus0.resp_ready = 1'b0;
        run0(4'd14, 4'b0000, 1'b1);
        wait_valid0();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus0.resp_valid), 32'd1);
            check("hold_resp", 32'(bus0.resp), 32'd0);
            check("hold_tie", 32'(bus0.tie_seen), 32'd1);
        end
        bus0.resp_ready = 1'b1;
        @(negedge clk);
        check("hs_valid_low", 32'(bus0.resp_valid), 32'd0);
        check("hs_busy_low", 32'(bus0.busy), 32'd0);
        check("hs_tie_held", 32'(bus0.tie_seen), 32'd1);

        // Reset during COUNT of bit 2
        set_periods(20, 40);
        run0(4'd3, 4'b1111, 1'b0);
        check("start_clears_tie", 32'(bus0.tie_seen), 32'd0);
        n = 0;
        while (chal_q.size() > 1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reached_bit2", 32'(chal_q.size()), 32'd1);
        repeat (10) @(negedge clk);
        check("pre_rst_resp", 32'(bus0.resp), 32'h3);
        #2 rst_n = 1'b1;
        #1;
        check("midrun_osc_en", 32'(bus0.osc_en), 32'd0);
        check("midrun_busy", 32'(bus0.busy), 32'd0);
        check("midrun_resp", 32'(bus0.resp), 32'd0);
        check("midrun_valid", 32'(bus0.resp_valid), 32'd0);
        resp_q.delete();
        chal_q.delete();
        @(negedge clk);
        rst_n = 1'b0;
        valid_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus0.resp_valid) valid_cnt++;
        end
        check("no_partial_valid", 32'(valid_cnt), 32'd0);
        check("post_rst_busy", 32'(bus0.busy), 32'd0);

        // 4-bit counters: 32 vs 16 edges both clip to 15 (tie); 32 vs 8 clips to 15 > 8
        set_periods(10, 20);
        run_sat(4'b0000, 1'b1);
        set_periods(10, 40);
        run_sat(4'b1111, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, vectors %0d", vec_cnt);
        $fatal(1, "watchdog");
    end

endmodule
